// File: rtl/fa_pkg.sv
// Shared constants for the NAND-only full adder family.
// Latency: none (constants only).
// Backpressure: not applicable.
package fa_pkg;

  // Operand width used when an instantiation does not override WIDTH.
  localparam int FA_WIDTH_DEFAULT = 1;

endpackage : fa_pkg

// File: rtl/fa_nand_cell.sv
// One-bit full adder built from exactly nine 2-input NAND gates.
// Latency: purely combinational.
// Backpressure: none; the cell simply evaluates its inputs.
module fa_nand_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Half-adder stage on a and b: n1 is the generate term (inverted),
  // x is a xor b.
  logic n1;
  logic n2;
  logic n3;
  logic x;

  // Second half-adder stage folds in the carry-in.
  logic n5;
  logic n6;
  logic n7;

  // Each gate is a NAND reduction of a two-bit concatenation.
  assign n1 = ~&{a, b};
  assign n2 = ~&{a, n1};
  assign n3 = ~&{b, n1};
  assign x  = ~&{n2, n3};

  assign n5 = ~&{x, ci};
  assign n6 = ~&{x, n5};
  assign n7 = ~&{ci, n5};

  // Sum is x xor ci; carry is (a and b) or (x and ci), both in NAND form.
  assign s  = ~&{n6, n7};
  assign co = ~&{n5, n1};

endmodule : fa_nand_cell

// File: rtl/fa_nand.sv
// WIDTH-bit ripple-carry adder of NAND-only cells, optionally registered.
// Latency: 1 cycle with REGISTER_OUT=1, combinational with REGISTER_OUT=0.
// Backpressure: none; a new qualified input is accepted every cycle.
module fa_nand
  import fa_pkg::*;
#(
  parameter int WIDTH        = FA_WIDTH_DEFAULT,
  parameter bit REGISTER_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
);

  // Carry chain: carry[0] is the external carry-in, carry[WIDTH] the carry-out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  assign carry[0] = cin;

  // One NAND cell per bit, each feeding its carry to the next bit up.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_nand_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (sum_comb[i]),
      .co (carry[i+1])
    );
  end

  if (REGISTER_OUT) begin : g_reg
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             valid_q;

    // Result register: captures only qualified inputs, valid tracks in_valid;
    // reset clears everything immediately, dropping any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q   <= '0;
        cout_q  <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= in_valid;
        if (in_valid) begin
          sum_q  <= sum_comb;
          cout_q <= carry[WIDTH];
        end
      end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = valid_q;
  end else begin : g_comb
    // Clock and reset play no part in the bypass; tie them off here so the
    // ports stay present for drop-in replacement of the registered variant.
    logic unused_clk_rst;
    assign unused_clk_rst = ~&{clk, rst_n};

    assign sum       = sum_comb;
    assign cout      = carry[WIDTH];
    assign out_valid = in_valid;
  end

endmodule : fa_nand

// File: tb/tb_fa_nand.sv
// Self-checking bench for fa_nand: 1-bit combinational and registered
// variants plus an 8-bit registered instance.
// Expected values come from a truth table and an arithmetic reference model.
module tb_fa_nand;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       a1, b1, cin1;
  logic [7:0] a8, b8;
  logic       cin8;

  logic       sum_c1, cout_c1, ov_c1;
  logic       sum_r1, cout_r1, ov_r1;
  logic [7:0] sum_r8;
  logic       cout_r8, ov_r8;

  int tests;
  int fails;

  fa_nand #(.WIDTH(1), .REGISTER_OUT(1'b0)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a1), .b(b1), .cin(cin1),
    .sum(sum_c1), .cout(cout_c1), .out_valid(ov_c1)
  );

  fa_nand #(.WIDTH(1), .REGISTER_OUT(1'b1)) u_r1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a1), .b(b1), .cin(cin1),
    .sum(sum_r1), .cout(cout_r1), .out_valid(ov_r1)
  );

  fa_nand #(.WIDTH(8), .REGISTER_OUT(1'b1)) u_r8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a8), .b(b8), .cin(cin8),
    .sum(sum_r8), .cout(cout_r8), .out_valid(ov_r8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic a;
    logic b;
    logic cin;
    logic s;
    logic co;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive the 8-bit operands at the falling edge, check one rising edge later.
  task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    in_valid = v;
    a8 = a;
    b8 = b;
    cin8 = c;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[8];

  initial begin
    logic [8:0] exp9;
    logic [8:0] held9;
    logic       exp_ov;
    logic [1:0] exp1;
    logic [1:0] held1;

    tests = 0;
    fails = 0;

    // Truth table of a one-bit full adder: {a,b,cin} -> {sum,cout}.
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0;
    in_valid = 1'b0;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    #12;

    // Reset state of the registered instances.
    chk("reset_r1", {29'd0, ov_r1, cout_r1, sum_r1}, 32'd0);
    chk("reset_r8", {22'd0, ov_r8, cout_r8, sum_r8}, 32'd0);

    // Combinational bypass ignores reset.
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b1; in_valid = 1'b1;
    #1;
    chk("comb_in_reset", {29'd0, ov_c1, cout_c1, sum_c1}, {29'd0, 1'b1, 1'b1, 1'b0});
    in_valid = 1'b0;

    @(negedge clk);
    rst_n = 1'b1;

    // Table walk: combinational result now, registered result one edge later.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a1 = vecs[i].a; b1 = vecs[i].b; cin1 = vecs[i].cin; in_valid = 1'b1;
      #1;
      chk($sformatf("comb_vec%0d", i), {30'd0, cout_c1, sum_c1}, {30'd0, vecs[i].co, vecs[i].s});
      chk($sformatf("comb_valid%0d", i), {31'd0, ov_c1}, 32'd1);
      after_edge();
      chk($sformatf("reg1_vec%0d", i), {29'd0, ov_r1, cout_r1, sum_r1}, {29'd0, 1'b1, vecs[i].co, vecs[i].s});
    end

    // 8-bit carry chain corners.
    drive8(1'b1, 8'hFF, 8'h01, 1'b0);
    after_edge();
    chk("ff_plus_01", {22'd0, ov_r8, cout_r8, sum_r8}, {22'd0, 1'b1, 1'b1, 8'h00});
    drive8(1'b1, 8'hFF, 8'h00, 1'b1);
    after_edge();
    chk("ff_plus_cin", {22'd0, ov_r8, cout_r8, sum_r8}, {22'd0, 1'b1, 1'b1, 8'h00});
    drive8(1'b1, 8'h5A, 8'h25, 1'b1);
    after_edge();
    chk("5a_25_1", {22'd0, ov_r8, cout_r8, sum_r8}, {22'd0, 1'b1, 1'b0, 8'h80});

    // Hold: one qualified input then several unqualified ones.
    drive8(1'b1, 8'h12, 8'h34, 1'b0);
    after_edge();
    chk("hold_capture", {22'd0, ov_r8, cout_r8, sum_r8}, {22'd0, 1'b1, 1'b0, 8'h46});
    for (int k = 0; k < 3; k++) begin
      drive8(1'b0, 8'hF0 + 8'(k), 8'h77, 1'b1);
      after_edge();
      chk($sformatf("hold%0d", k), {22'd0, ov_r8, cout_r8, sum_r8}, {22'd0, 1'b0, 1'b0, 8'h46});
    end

    // Async reset between edges while a valid result is on the outputs.
    drive8(1'b1, 8'h5A, 8'h25, 1'b1);
    after_edge();
    chk("pre_reset", {22'd0, ov_r8, cout_r8, sum_r8}, {22'd0, 1'b1, 1'b0, 8'h80});
    drive8(1'b1, 8'hFF, 8'hFF, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {22'd0, ov_r8, cout_r8, sum_r8}, 32'd0);
    after_edge();
    chk("reset_held_edge", {22'd0, ov_r8, cout_r8, sum_r8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; in_valid = 1'b1;
    after_edge();
    chk("first_after_reset", {22'd0, ov_r8, cout_r8, sum_r8}, {22'd0, 1'b1, 1'b0, 8'h30});

    // Random vectors against an arithmetic reference; unqualified cycles
    // must leave the previously captured result in place.
    held9 = {cout_r8, sum_r8};
    held1 = {cout_r1, sum_r1};
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 7) != 0);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      cin8 = 1'($urandom);
      a1 = 1'($urandom);
      b1 = 1'($urandom);
      cin1 = 1'($urandom);
      exp_ov = in_valid;
      exp9 = 9'(a8) + 9'(b8) + 9'(cin8);
      exp1 = 2'(a1) + 2'(b1) + 2'(cin1);
      if (in_valid) begin
        held9 = exp9;
        held1 = exp1;
      end
      #1;
      chk($sformatf("rand_comb%0d", n), {29'd0, ov_c1, cout_c1, sum_c1}, {29'd0, exp_ov, exp1});
      after_edge();
      chk($sformatf("rand_r8_%0d", n), {22'd0, ov_r8, cout_r8, sum_r8}, {22'd0, exp_ov, held9});
      chk($sformatf("rand_r1_%0d", n), {29'd0, ov_r1, cout_r1, sum_r1}, {29'd0, exp_ov, held1});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_fa_nand
